// File: rtl/tft_timing_pkg.sv
// tft_timing_pkg: shared TFT timing constants, vertical FSM encoding and phase helper
// Holds the 1280x1024 horizontal and vertical defaults used by h_sync and v_sync_gen.
package tft_timing_pkg;

    localparam int H_PULSE_PIX   = 112;
    localparam int H_BP_PIX      = 248;
    localparam int H_ACTIVE_PIX  = 1280;
    localparam int H_FP_PIX      = 48;
    localparam int H_CNT_W_DEF   = 11;

    localparam int V_PULSE_DEF   = 3;
    localparam int V_BP_DEF      = 38;
    localparam int V_PIX_DEF     = 1024;
    localparam int V_FP_DEF      = 1;
    localparam int V_CNT_W_DEF   = 11;

    typedef enum logic [4:0] {
        SET_COUNTERS = 5'b00001,
        PULSE        = 5'b00010,
        BACK_PORCH   = 5'b00100,
        PIXEL        = 5'b01000,
        FRONT_PORCH  = 5'b10000
    } v_state_t;

    // Phase order within a frame; anything unexpected falls back to a restart.
    function automatic v_state_t v_next_phase(input v_state_t s);
        return (s == PULSE)       ? BACK_PORCH :
               (s == BACK_PORCH)  ? PIXEL :
               (s == PIXEL)       ? FRONT_PORCH :
               (s == FRONT_PORCH) ? PULSE : SET_COUNTERS;
    endfunction

endpackage

// File: rtl/tft_line_tick.sv
// tft_line_tick: HSYNC falling-edge detector producing one line tick per line
// Ports: Clk pixel clock, Rst_n async active-low reset, HSYNC active-low horizontal sync,
//        tick high for the single cycle in which HSYNC first reads low.
module tft_line_tick (
    input  logic Clk,
    input  logic Rst_n,
    input  logic HSYNC,
    output logic tick
);

    logic hsync_d;

    // Reset to 1 so an HSYNC already low out of reset still counts as a fresh edge.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) hsync_d <= 1'b1;
        else        hsync_d <= HSYNC;

    assign tick = hsync_d & ~HSYNC;

endmodule

// File: rtl/v_sync_gen.sv
// v_sync_gen: vertical timing generator (VSYNC, V_DE, pixel DE, frame start) for the TFT path
// Ports: Clk pixel clock, Rst_n async active-low reset, HSYNC/H_DE/VSYNC_Rst from h_sync,
//        VSYNC active-low vertical sync, V_DE active-line enable, DE = H_DE & V_DE,
//        V_frame_start one-cycle pulse on PULSE entry, V_line active line index.
// Optional: define V_LINE_IDX_EN to add the V_line port and its register.
module v_sync_gen
    import tft_timing_pkg::*;
#(
    parameter int V_PULSE_LINES = V_PULSE_DEF,
    parameter int V_BP_LINES    = V_BP_DEF,
    parameter int V_PIX_LINES   = V_PIX_DEF,
    parameter int V_FP_LINES    = V_FP_DEF,
    parameter int V_CNT_W       = V_CNT_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               HSYNC,
    input  logic               H_DE,
    input  logic               VSYNC_Rst,
    output logic               VSYNC,
    output logic               V_DE,
    output logic               DE,
    output logic               V_frame_start
`ifdef V_LINE_IDX_EN
    ,
    output logic [V_CNT_W-1:0] V_line
`endif
);

    localparam logic [V_CNT_W-1:0] L_PULSE = V_CNT_W'(V_PULSE_LINES - 1);
    localparam logic [V_CNT_W-1:0] L_BP    = V_CNT_W'(V_BP_LINES - 1);
    localparam logic [V_CNT_W-1:0] L_PIX   = V_CNT_W'(V_PIX_LINES - 1);
    localparam logic [V_CNT_W-1:0] L_FP    = V_CNT_W'(V_FP_LINES - 1);

    v_state_t           state, state_nxt;
    logic [V_CNT_W-1:0] cnt, cnt_nxt, lim;
    logic               tick;

    tft_line_tick u_tick (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .HSYNC (HSYNC),
        .tick  (tick)
    );

    always_comb begin
        lim = (state == PULSE)      ? L_PULSE :
              (state == BACK_PORCH) ? L_BP :
              (state == PIXEL)      ? L_PIX : L_FP;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (VSYNC_Rst) begin
            state_nxt = SET_COUNTERS;
            cnt_nxt   = '0;
        end else begin
            case (state)
                SET_COUNTERS: begin
                    cnt_nxt = '0;
                    if (tick) state_nxt = PULSE;
                end
                PULSE, BACK_PORCH, PIXEL, FRONT_PORCH:
                    if (tick) begin
                        // >= keeps a corrupted count from running past the phase length.
                        cnt_nxt   = (cnt >= lim) ? '0 : cnt + V_CNT_W'(1);
                        state_nxt = (cnt >= lim) ? v_next_phase(state) : state;
                    end
                default: begin
                    state_nxt = SET_COUNTERS;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            state         <= SET_COUNTERS;
            cnt           <= '0;
            VSYNC         <= 1'b1;
            V_DE          <= 1'b0;
            V_frame_start <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            VSYNC         <= state_nxt != PULSE;
            V_DE          <= state_nxt == PIXEL;
            V_frame_start <= (state_nxt == PULSE) && (state != PULSE);
        end

`ifdef V_LINE_IDX_EN
    // Tracks the counter through PIXEL and then holds the final active line index.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) V_line <= '0;
        else        V_line <= (state_nxt == PIXEL) ? cnt_nxt : VSYNC_Rst ? '0 : V_line;
`endif

    assign DE = H_DE & V_DE;

endmodule

// File: tb/tb_v_sync_gen.sv
// tb_v_sync_gen: directed self-checking bench for v_sync_gen with 2/3/4/1 lines and 20-clk lines
module tb_v_sync_gen;

    logic        Clk = 1'b0;
    logic        Rst_n, HSYNC, H_DE, VSYNC_Rst;
    logic        VSYNC, V_DE, DE, V_frame_start;
`ifdef V_LINE_IDX_EN
    logic [10:0] V_line;
`endif

    int checks = 0, errors = 0;
    int ln = 0, origin = 0, cyc = 0, n_vs = 0, n_de = 0;
    int fs_cyc[$];

    v_sync_gen #(
        .V_PULSE_LINES (2),
        .V_BP_LINES    (3),
        .V_PIX_LINES   (4),
        .V_FP_LINES    (1),
        .V_CNT_W       (11)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .HSYNC         (HSYNC),
        .H_DE          (H_DE),
        .VSYNC_Rst     (VSYNC_Rst),
        .VSYNC         (VSYNC),
        .V_DE          (V_DE),
        .DE            (DE),
        .V_frame_start (V_frame_start)
`ifdef V_LINE_IDX_EN
        ,
        .V_line        (V_line)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, leave time for outputs to settle.
    task automatic step(input logic hs, input logic hde, input logic vr);
        @(posedge Clk);
        #1;
        HSYNC     = hs;
        H_DE      = hde;
        VSYNC_Rst = vr;
        #3;
        cyc++;
    endtask

    // One 20-clk line: HSYNC low for clocks 0..2, H_DE high for clocks 8..17.
    // Expected vertical position counts lines from the first PULSE line (origin).
    task automatic line(input logic vr);
        for (int p = 0; p < 20; p++) begin
            int pos, e, evl;
            logic hde, evs, ede, efs;
            hde = (p >= 8) && (p < 18);
            step((p < 3) ? 1'b0 : 1'b1, hde, (p == 0) ? vr : 1'b0);
            pos = ((p >= 1) ? ln : ln - 1) - origin;
            e   = (pos < 0) ? -1 : pos % 10;
            evs = !((e == 0) || (e == 1));
            ede = (e >= 5) && (e <= 8);
            efs = (e == 0) && (pos % 10 == 0) && (p == 1);
            evl = ede ? e - 5 : (pos >= 9) ? 3 : 0;
            chk("vsync", VSYNC, evs);
            chk("v_de", V_DE, ede);
            chk("frame_start", V_frame_start, efs);
            chk("de", DE, hde & ede);
`ifdef V_LINE_IDX_EN
            chk("v_line", V_line, evl);
`endif
            if (!VSYNC) n_vs++;
            if (V_DE) n_de++;
            if (V_frame_start) fs_cyc.push_back(cyc);
            if ((p == 0) && vr) origin = ln + 1;
        end
        ln++;
    endtask

    task automatic restart();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        H_DE  = 1'b0;
        origin = ln;
        step(1'b1, 1'b0, 1'b1);
        chk("post_rst_vsync", VSYNC, 1);
        chk("post_rst_v_de", V_DE, 0);
    endtask

    initial begin
        Rst_n = 1'b0;
        HSYNC = 1'b1;
        H_DE = 1'b1;
        VSYNC_Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_vsync", VSYNC, 1);
        chk("rst_v_de", V_DE, 0);
        chk("rst_frame_start", V_frame_start, 0);
        chk("rst_de", DE, 0);
`ifdef V_LINE_IDX_EN
        chk("rst_v_line", V_line, 0);
`endif
        restart();

        // Two full frames from the first tick.
        n_vs = 0;
        n_de = 0;
        fs_cyc.delete();
        repeat (20) line(1'b0);
        chk("vsync_low_clks", n_vs, 80);
        chk("v_de_high_clks", n_de, 160);
        chk("frame_start_count", fs_cyc.size(), 2);
        if (fs_cyc.size() == 2) chk("frame_period", fs_cyc[1] - fs_cyc[0], 200);

        // VSYNC_Rst together with the tick that ends PIXEL line 2.
        repeat (8) line(1'b0);
        line(1'b1);
        line(1'b0);
        chk("restart_pulse_vsync", VSYNC, 0);

        // Async reset in the middle of BACK_PORCH.
        repeat (2) line(1'b0);
        #2;
        H_DE = 1'b1;
        Rst_n = 1'b0;
        #1;
        chk("bp_rst_vsync", VSYNC, 1);
        chk("bp_rst_v_de", V_DE, 0);
        chk("bp_rst_frame_start", V_frame_start, 0);
        chk("bp_rst_de", DE, 0);
        restart();

        // Async reset during PULSE must release VSYNC without a clock.
        line(1'b0);
        chk("pre_pulse_rst_vsync", VSYNC, 0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("pulse_rst_vsync", VSYNC, 1);
        restart();

        // Async reset during PIXEL must drop V_DE and DE without a clock.
        repeat (7) line(1'b0);
        chk("pre_pix_rst_v_de", V_DE, 1);
        #2;
        H_DE = 1'b1;
        Rst_n = 1'b0;
        #1;
        chk("pix_rst_v_de", V_DE, 0);
        chk("pix_rst_de", DE, 0);
`ifdef V_LINE_IDX_EN
        chk("pix_rst_v_line", V_line, 0);
`endif
        restart();
        repeat (10) line(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
